// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: N_SRC valid/ready source streams share one sink.
// Latency: 1 arbitration cycle per grant, then zero-latency combinational pass-through.
// Backpressure: m_ready_i goes straight to s_ready_o of the granted source only.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   s_data_i          N_SRC packed source words, source k at [k*DW +: DW]
//   s_valid_i/last_i  per-source valid and end-of-packet
//   s_ready_o         per-source ready (only the granted source sees m_ready_i)
//   m_data_o/valid_o  granted stream towards the sink
//   m_last_o          end of packet, also raised on a forced MAX_BEATS release
//   m_id_o            index of the granted source
//   m_ready_i         sink ready
module stream_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DW        = 16,
  parameter int MAX_BEATS = 0,
  parameter int IDW       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC*DW-1:0] s_data_i,
  input  logic [N_SRC-1:0]    s_valid_i,
  input  logic [N_SRC-1:0]    s_last_i,
  output logic [N_SRC-1:0]    s_ready_o,
  output logic [DW-1:0]       m_data_o,
  output logic                m_valid_o,
  output logic                m_last_o,
  output logic [IDW-1:0]      m_id_o,
  input  logic                m_ready_i
);

  // Beat counter is kept at least 1 bit wide even when the limit is disabled.
  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CW-1:0] FORCE_AT = (MAX_BEATS > 0) ? CW'(MAX_BEATS - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic           hi_vld, lo_vld;
  logic [IDW-1:0] hi_idx, lo_idx, pick_idx;
  logic           g_valid, g_last, forced_last, xfer;
  logic [DW-1:0]  g_data;

  // Round-robin pick: lowest requester at or above rr_ptr wins, otherwise
  // wrap around to the lowest requester overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!hi_vld && s_valid_i[k] && (IDW'(k) >= rr_ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IDW'(k);
      end
      if (!lo_vld && s_valid_i[k]) begin
        lo_vld = 1'b1;
        lo_idx = IDW'(k);
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Select the granted source with constant indices.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == IDW'(k)) begin
        g_valid = s_valid_i[k];
        g_last  = s_last_i[k];
        g_data  = s_data_i[k*DW +: DW];
      end
    end
  end

  generate
    if (MAX_BEATS > 0) begin : g_limit
      assign forced_last = (beat_cnt_q == FORCE_AT);
    end else begin : g_nolimit
      assign forced_last = 1'b0;
    end
  endgenerate

  // Outputs are gated by rst_n so nothing can transfer while reset is held,
  // even in the cycle before the state register has been cleared.
  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    m_id_o    = '0;
    if (rst_n && (state_q == BUSY)) begin
      m_valid_o = g_valid;
      m_data_o  = g_data;
      m_last_o  = g_last | forced_last;
      m_id_o    = grant_q;
      for (int k = 0; k < N_SRC; k++) begin
        s_ready_o[k] = (grant_q == IDW'(k)) & m_ready_i;
      end
    end
  end

  assign xfer = m_valid_o & m_ready_i;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (lo_vld) begin
          state_d    = BUSY;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        // Grant stays put while the source idles; only a last beat releases it.
        if (xfer) begin
          if (beat_cnt_q != {CW{1'b1}}) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
          if (m_last_o) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == IDW'(N_SRC - 1)) ? '0 : grant_q + IDW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
